// File: rtl/event_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : event_stretcher
// Description : Turns single-cycle event strobes into human-visible LED
//               pulses. Each accepted event produces a fixed ON_CYCLES high
//               pulse on led followed by a mandatory GAP_CYCLES low gap.
//               Events arriving while a pulse or gap is in progress are
//               queued in a saturating pending counter and replayed in order.
//
// Ports       : clk      - clock, all logic on the rising edge
//               rst      - synchronous active-high reset
//               evt      - event strobe, one event per high cycle
//               clr      - discard queued events and clear overflow; the
//                          pulse or gap in progress still completes
//               led      - stretched indicator (registered)
//               busy     - high whenever a pulse or gap is active (registered)
//               pending  - queued events not yet started (registered)
//               overflow - sticky, an event was lost to saturation
//
// Revision    : 1.0 - initial release
// ============================================================================
module event_stretcher #(
    parameter int ON_CYCLES  = 8000000,
    parameter int GAP_CYCLES = 4000000,
    parameter int CNT_W      = 24,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              evt,
    input  logic              clr,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    // ------------------------------------------------------------------------
    // State encoding and terminal counts
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ON   = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    localparam logic [CNT_W-1:0]  c_ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] c_PEND_MAX = '1;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [PEND_W-1:0] pend_q,  pend_d;
    logic              ovf_q,   ovf_d;
    logic              led_q,   led_d;
    logic              busy_q,  busy_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    // An event coincident with clr is discarded in every state.
    logic w_evt_acc;
    // The event is consumed by starting a pulse right away, never queued.
    logic w_evt_direct;
    // A queued event is being launched on this GAP-exit cycle.
    logic w_pend_dec;

    assign w_evt_acc = evt & ~clr;

    // ------------------------------------------------------------------------
    // Sequencer: IDLE -> ON -> GAP -> (ON | IDLE)
    // The terminal compare is evaluated before the increment, so the counter
    // never reaches a value past the longer of the two phase lengths and
    // therefore never wraps.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        w_evt_direct = 1'b0;
        w_pend_dec   = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                if (w_evt_acc) begin
                    state_d      = c_ST_ON;
                    cnt_d        = '0;
                    w_evt_direct = 1'b1;
                end
            end

            c_ST_ON: begin
                if (cnt_q == c_ON_LAST) begin
                    state_d = c_ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            c_ST_GAP: begin
                if (cnt_q == c_GAP_LAST) begin
                    cnt_d = '0;
                    if (clr) begin
                        // Queue is being flushed: nothing left to replay.
                        state_d = c_ST_IDLE;
                    end else if (pend_q != '0) begin
                        state_d    = c_ST_ON;
                        w_pend_dec = 1'b1;
                    end else if (evt) begin
                        // Fresh event on the exit cycle chains straight into
                        // the next pulse instead of passing through IDLE.
                        state_d      = c_ST_ON;
                        w_evt_direct = 1'b1;
                    end else begin
                        state_d = c_ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = c_ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pending queue and overflow flag
    // A queued launch and a new event in the same cycle cancel out, so a
    // saturated queue does not flag overflow when a slot is being freed.
    // ------------------------------------------------------------------------
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;

        if (clr) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end else if (w_evt_acc && !w_evt_direct) begin
            if (w_pend_dec) begin
                pend_d = pend_q;
            end else if (pend_q == c_PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (w_pend_dec) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // Outputs are decoded from the next state and registered so that no
    // combinational path runs from the inputs to the pins.
    assign led_d  = (state_d == c_ST_ON);
    assign busy_d = (state_d != c_ST_IDLE);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_event_stretcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_stretcher
// Description : Directed self-checking bench for event_stretcher with
//               ON_CYCLES=4, GAP_CYCLES=2, PEND_W=2. Cycle numbers count
//               from the first cycle after reset release; inputs set for
//               cycle c are sampled at the edge ending cycle c, and outputs
//               are observed 1 time unit after that edge (cycle c+1).
//               Each output sample is the vector {led, busy, pending, overflow}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_stretcher;

    localparam int ON_CYCLES  = 4;
    localparam int GAP_CYCLES = 2;
    localparam int CNT_W      = 3;
    localparam int PEND_W     = 2;

    logic              clk;
    logic              rst;
    logic              evt;
    logic              clr;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    int total;
    int bad;
    int cyc;

    logic              exp_led;
    logic              exp_busy;
    logic [PEND_W-1:0] exp_pend;
    logic              exp_ovf;
    logic [4:0]        exp_vec;
    logic [4:0]        got_vec;

    event_stretcher #(
        .ON_CYCLES  (ON_CYCLES),
        .GAP_CYCLES (GAP_CYCLES),
        .CNT_W      (CNT_W),
        .PEND_W     (PEND_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .evt      (evt),
        .clr      (clr),
        .led      (led),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_test;
        rst = 1'b1;
        evt = 1'b0;
        clr = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        cyc = 0;
    endtask

    // Reset with evt and clr asserted must still yield all-zero outputs.
    task automatic test_reset;
        rst = 1'b1;
        evt = 1'b1;
        clr = 1'b1;
        tick;
        tick;
        got_vec = {led, busy, pending, overflow};
        total++;
        if (got_vec !== 5'b0) begin
            bad++;
            $display("FAIL reset got=%b exp=%b", got_vec, 5'b0);
        end
        evt = 1'b0;
        clr = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single;
        start_test;
        while (cyc < 20) begin
            evt = (cyc == 10);
            tick;
            exp_led  = cyc inside {[11:14]};
            exp_busy = cyc inside {[11:16]};
            exp_pend = 2'd0;
            exp_ovf  = 1'b0;
            exp_vec  = {exp_led, exp_busy, exp_pend, exp_ovf};
            got_vec  = {led, busy, pending, overflow};
            total++;
            if (got_vec !== exp_vec) begin
                bad++;
                $display("FAIL single cyc=%0d got=%b exp=%b", cyc, got_vec, exp_vec);
            end
        end
        evt = 1'b0;
    endtask

    task automatic test_queue;
        start_test;
        while (cyc < 38) begin
            evt = cyc inside {10, 12, 13, 15};
            tick;
            exp_led  = cyc inside {[11:14], [17:20], [23:26], [29:32]};
            exp_busy = cyc inside {[11:34]};
            if (cyc == 13)                exp_pend = 2'd1;
            else if (cyc inside {[14:15]}) exp_pend = 2'd2;
            else if (cyc == 16)           exp_pend = 2'd3;
            else if (cyc inside {[17:22]}) exp_pend = 2'd2;
            else if (cyc inside {[23:28]}) exp_pend = 2'd1;
            else                          exp_pend = 2'd0;
            exp_ovf  = 1'b0;
            exp_vec  = {exp_led, exp_busy, exp_pend, exp_ovf};
            got_vec  = {led, busy, pending, overflow};
            total++;
            if (got_vec !== exp_vec) begin
                bad++;
                $display("FAIL queue cyc=%0d got=%b exp=%b", cyc, got_vec, exp_vec);
            end
        end
        evt = 1'b0;
    endtask

    // Six events on cycles 10..15: one starts at once, three queue, two are lost.
    task automatic test_saturation;
        start_test;
        while (cyc < 40) begin
            evt = cyc inside {[10:15]};
            tick;
            exp_led  = cyc inside {[11:14], [17:20], [23:26], [29:32]};
            exp_busy = cyc inside {[11:34]};
            if (cyc == 12)                exp_pend = 2'd1;
            else if (cyc == 13)           exp_pend = 2'd2;
            else if (cyc inside {[14:16]}) exp_pend = 2'd3;
            else if (cyc inside {[17:22]}) exp_pend = 2'd2;
            else if (cyc inside {[23:28]}) exp_pend = 2'd1;
            else                          exp_pend = 2'd0;
            exp_ovf  = (cyc >= 15);
            exp_vec  = {exp_led, exp_busy, exp_pend, exp_ovf};
            got_vec  = {led, busy, pending, overflow};
            total++;
            if (got_vec !== exp_vec) begin
                bad++;
                $display("FAIL saturation cyc=%0d got=%b exp=%b", cyc, got_vec, exp_vec);
            end
        end
        evt = 1'b0;
    endtask

    // clr mid-GAP with a coincident evt, clr+evt in IDLE, and clr on the
    // GAP-exit cycle while an event is queued.
    task automatic test_clear;
        start_test;
        while (cyc < 36) begin
            evt = cyc inside {10, 11, 12, 15, 20, 25, 26};
            clr = cyc inside {15, 20, 31};
            tick;
            exp_led  = cyc inside {[11:14], [26:29]};
            exp_busy = cyc inside {[11:16], [26:31]};
            if (cyc == 12)                 exp_pend = 2'd1;
            else if (cyc inside {[13:15]})  exp_pend = 2'd2;
            else if (cyc inside {[27:31]})  exp_pend = 2'd1;
            else                           exp_pend = 2'd0;
            exp_ovf  = 1'b0;
            exp_vec  = {exp_led, exp_busy, exp_pend, exp_ovf};
            got_vec  = {led, busy, pending, overflow};
            total++;
            if (got_vec !== exp_vec) begin
                bad++;
                $display("FAIL clear cyc=%0d got=%b exp=%b", cyc, got_vec, exp_vec);
            end
        end
        evt = 1'b0;
        clr = 1'b0;
    endtask

    task automatic test_reset_mid_on;
        start_test;
        while (cyc < 25) begin
            evt = cyc inside {[9:12]};
            rst = (cyc == 12);
            tick;
            if (cyc >= 13) begin
                exp_led  = 1'b0;
                exp_busy = 1'b0;
                exp_pend = 2'd0;
            end else begin
                exp_led  = (cyc >= 10);
                exp_busy = (cyc >= 10);
                if (cyc == 11)      exp_pend = 2'd1;
                else if (cyc == 12) exp_pend = 2'd2;
                else                exp_pend = 2'd0;
            end
            exp_ovf  = 1'b0;
            exp_vec  = {exp_led, exp_busy, exp_pend, exp_ovf};
            got_vec  = {led, busy, pending, overflow};
            total++;
            if (got_vec !== exp_vec) begin
                bad++;
                $display("FAIL reset_mid_on cyc=%0d got=%b exp=%b", cyc, got_vec, exp_vec);
            end
        end
        evt = 1'b0;
        rst = 1'b0;
    endtask

    // evt on the final GAP cycle: first with one event queued (cancels),
    // then with an empty queue (chains directly into ON).
    task automatic test_back_to_back;
        start_test;
        while (cyc < 56) begin
            evt = cyc inside {10, 12, 16, 40, 46};
            tick;
            exp_led  = cyc inside {[11:14], [17:20], [23:26], [41:44], [47:50]};
            exp_busy = cyc inside {[11:28], [41:52]};
            exp_pend = (cyc inside {[13:22]}) ? 2'd1 : 2'd0;
            exp_ovf  = 1'b0;
            exp_vec  = {exp_led, exp_busy, exp_pend, exp_ovf};
            got_vec  = {led, busy, pending, overflow};
            total++;
            if (got_vec !== exp_vec) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, got_vec, exp_vec);
            end
        end
        evt = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        evt   = 1'b0;
        clr   = 1'b0;

        test_reset;
        test_single;
        test_queue;
        test_saturation;
        test_clear;
        test_reset_mid_on;
        test_back_to_back;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/event_stretcher.md
Name: event_stretcher

Overview:
- Output-side counterpart to the button input conditioning: turns 1-cycle event pulses (e.g. press/release strobes) into human-visible LED pulses.
- Each accepted event gives a fixed-length high pulse on led, followed by a mandatory low gap.
- Events arriving while a pulse or gap is in progress are queued in a saturating pending counter and replayed in order.
- Sits between event-producing logic and board LEDs or other slow physical indicators.

Parameters:
- ON_CYCLES, 8000000, cycles led is held high per event (must be >= 1).
- GAP_CYCLES, 4000000, cycles led is held low between consecutive pulses (must be >= 1).
- CNT_W, 24, width of the internal duration counter; must hold max(ON_CYCLES, GAP_CYCLES)-1.
- PEND_W, 4, width of the pending-event counter; saturates at 2^PEND_W-1.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- evt  input  1  event strobe; each high cycle is one event.
- clr  input  1  discards queued events and clears overflow; does not abort the current pulse or gap.
- led  output  1  stretched indicator output, registered.
- busy  output  1  high whenever state is not IDLE, registered.
- pending  output  PEND_W  number of queued events not yet started, registered.
- overflow  output  1  sticky; set when an event is lost to saturation.

Behaviour:
- Reset: on rst at an edge, state goes to IDLE and all outputs go to 0 (led, busy, pending, overflow, counter). rst overrides evt and clr in the same cycle.
- States:
  - IDLE: led=0, busy=0.
  - ON: led=1, busy=1.
  - GAP: led=0, busy=1.
- IDLE:
  - evt=1 and clr=0 at edge k → ON from edge k; counter=0.
  - led is high in cycles k+1 .. k+ON_CYCLES, i.e. latency 1 cycle.
  - The event goes straight to ON; pending stays 0.
- ON:
  - Counter increments each cycle.
  - When counter==ON_CYCLES-1 → GAP, counter=0.
  - led is high for exactly ON_CYCLES cycles.
- GAP:
  - Counter increments each cycle.
  - When counter==GAP_CYCLES-1 and pending>0 → ON, pending decremented by 1.
  - When counter==GAP_CYCLES-1 and pending==0 → IDLE.
  - led is low for exactly GAP_CYCLES cycles.
  - Pulse period for queued events is ON_CYCLES+GAP_CYCLES.
- evt while in ON or GAP:
  - pending+1, saturating at 2^PEND_W-1.
  - evt while pending is already saturated (and not simultaneously decrementing): pending unchanged, overflow<=1.
- evt on the GAP-exit cycle with pending>0: the increment and decrement cancel; pending unchanged, ON entered.
- evt on the GAP-exit cycle with pending==0: pending is unaffected; state goes to ON instead of IDLE, and the event is consumed directly.
- clr=1:
  - Next cycle pending=0 and overflow=0.
  - An evt in the same cycle is discarded in every state.
  - The current ON/GAP completes normally, then the block returns to IDLE.
  - clr on the GAP-exit cycle forces IDLE.
- overflow stays set until rst or clr.
- Counter arithmetic is CNT_W-bit unsigned and is never allowed to wrap (terminal compare precedes increment).
- No combinational path from inputs to outputs.

Test Plan (ON_CYCLES=4, GAP_CYCLES=2, PEND_W=2):
- Single event: evt high cycle 10 only → led=1 cycles 11–14, led=0 cycles 15–16, busy=1 cycles 11–16, busy=0 from cycle 17; pending stays 0.
- Queuing: evt cycles 10, 12, 13, 15 → pending 1, 2, 3 after those cycles; led rises at cycles 11, 17, 23, 29, each for 4 cycles; pending shows 2, 1, 0 after cycles 16, 22, 28; busy falls after cycle 34.
- Saturation: evt cycle 10 then five more evts during ON/GAP → pending=3, overflow=1; exactly 4 led pulses; overflow stays 1 afterwards.
- Clear: with pending=2 during GAP, pulse clr one cycle → pending=0 and overflow=0 next cycle; led stays low; block reaches IDLE at gap end; evt coincident with clr produces no pulse.
- Reset: assert rst at cycle 12 mid-ON with pending=2 and evt=1 → from cycle 13 led=0, busy=0, pending=0, overflow=0; no further pulses.
- Coincidence: pending=1 and evt on the final GAP cycle → pending stays 1; ON starts on the next cycle; one more pulse follows after this one.
